// File: rtl/fp_mult_serial.sv
// -----------------------------------------------------------------------------
// fp_mult_serial
//
// Byte-serial IEEE-754 multiplier with a parameterised format. Two operands
// arrive MSB byte first over an 8-bit port (A then B). The block classifies
// them, normalises subnormal significands, and forms the significand product
// with an iterative shift-add multiplier. It then rounds to nearest-even,
// including gradual underflow, and streams the result back MSB byte first.
// Latency is fixed and does not depend on operand class.
//
// Parameters
//   EXP_W      exponent width (>= 3)
//   FRAC_W     stored fraction width; 1+EXP_W+FRAC_W must be a multiple of 8
//   MULT_STEP  multiplier-operand bits consumed per MULT cycle
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous, active-high reset
//   ENABLE    in   DATA_IN valid this cycle (only honoured while loading)
//   DATA_IN   in   [7:0] operand byte
//   DATA_OUT  out  [7:0] result byte while READY, zero otherwise
//   READY     out  high for exactly NB consecutive cycles per result
// -----------------------------------------------------------------------------
module fp_mult_serial #(
  parameter int EXP_W     = 11,
  parameter int FRAC_W    = 52,
  parameter int MULT_STEP = 14
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       READY
);

  localparam int W     = 1 + EXP_W + FRAC_W;           // operand width
  localparam int NB    = W / 8;                        // bytes per operand
  localparam int SW    = FRAC_W + 1;                   // significand width
  localparam int PW    = 2 * SW;                       // product width
  localparam int K     = (SW + MULT_STEP - 1) / MULT_STEP;
  localparam int KW    = K * MULT_STEP;                // padded multiplier width
  localparam int XW    = EXP_W + 2;                    // signed exponent width
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int MAX_E = (1 << EXP_W) - 1;             // all-ones biased exponent
  localparam int CW    = $clog2(2 * NB + K + 1);
  localparam int SHW   = $clog2(SW + 1);

  localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
  localparam logic [FRAC_W-1:0] QUIET_BIT = FRAC_W'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLASS,
    S_NORM,
    S_MULT,
    S_RND,
    S_OUT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;          // load bytes / mult steps / out bytes

  logic [W-1:0]           a_reg;
  logic [W-1:0]           b_reg;

  logic                   special;      // result fixed by operand classes
  logic [W-1:0]           spec_res;
  logic                   sign_r;

  logic signed [XW-1:0]   exp_sum;      // unbiased exponent of the product
  logic [PW-1:0]          a_shift;      // multiplicand, pre-shifted per step
  logic [KW-1:0]          b_rem;        // multiplier bits not yet consumed
  logic [PW-1:0]          prod;

  logic [W-1:0]           out_sr;       // result bytes still to be sent

  // ---------------------------------------------------------------------------
  // Operand fields and classification
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              res_sign;

  assign a_exp    = a_reg[W-2 -: EXP_W];
  assign b_exp    = b_reg[W-2 -: EXP_W];
  assign a_frac   = a_reg[FRAC_W-1:0];
  assign b_frac   = b_reg[FRAC_W-1:0];
  assign a_zero   = (a_exp == '0) && (a_frac == '0);
  assign b_zero   = (b_exp == '0) && (b_frac == '0);
  assign a_inf    = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf    = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan    = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan    = (b_exp == EXP_ONES) && (b_frac != '0);
  assign res_sign = a_reg[W-1] ^ b_reg[W-1];

  logic         cls_special;
  logic [W-1:0] cls_res;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cls_special = 1'b1;
    cls_res     = '0;
    if (a_nan) begin
      cls_res = a_reg | W'(QUIET_BIT);
    end else if (b_nan) begin
      cls_res = b_reg | W'(QUIET_BIT);
    end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      cls_res = {1'b0, EXP_ONES, QUIET_BIT};
    end else if (a_inf || b_inf) begin
      cls_res = {res_sign, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      cls_res = {res_sign, {(W-1){1'b0}}};
    end else begin
      cls_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Significand normalisation
  // ---------------------------------------------------------------------------
  // Left shift that brings the leading one to the MSB. The loop runs upward so
  // the highest set bit has the final say. Normals already have MSB set.
  function automatic logic [SHW-1:0] lead_shift(input logic [SW-1:0] s);
    lead_shift = '0;
    for (int i = 0; i < SW; i++) begin
      if (s[i]) lead_shift = SHW'(SW - 1 - i);
    end
  endfunction

  // Subnormals use an effective exponent field of 1, less the normalising shift.
  function automatic logic signed [XW-1:0] unbias(input logic [EXP_W-1:0] e,
                                                   input logic [SHW-1:0]   sh);
    logic [XW-1:0] e_eff;
    e_eff = (e == '0) ? XW'(1) : XW'(e);
    return signed'(e_eff - XW'(BIAS) - XW'(sh));
  endfunction

  logic [SW-1:0]        a_sig_raw, b_sig_raw, a_sig_n, b_sig_n;
  logic [SHW-1:0]       a_sh, b_sh;
  logic signed [XW-1:0] a_exp_n, b_exp_n;

  always_comb begin
    a_sig_raw = {a_exp != '0, a_frac};
    b_sig_raw = {b_exp != '0, b_frac};
    a_sh      = lead_shift(a_sig_raw);
    b_sh      = lead_shift(b_sig_raw);
    a_sig_n   = a_sig_raw << a_sh;
    b_sig_n   = b_sig_raw << b_sh;
    a_exp_n   = unbias(a_exp, a_sh);
    b_exp_n   = unbias(b_exp, b_sh);
  end

  // ---------------------------------------------------------------------------
  // Normalise, denormalise, round
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        norm, shifted;
  logic signed [XW-1:0] e_b;            // biased exponent before rounding
  logic                 e_le0, e_ovf;
  logic [XW-1:0]        sh_amt;
  logic                 lost, guard, sticky, inc;
  logic [FRAC_W-1:0]    frac_p;
  logic [EXP_W-1:0]     exp_enc;
  logic [W-2:0]         mag, mag_r;
  logic [W-1:0]         rnd_res;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4): at most one shift.
    if (prod[PW-1]) begin
      norm = prod;
      e_b  = exp_sum + XW'(BIAS + 1);
    end else begin
      norm = prod << 1;
      e_b  = exp_sum + XW'(BIAS);
    end
    e_le0 = e_b[XW-1] || (e_b == '0);
    e_ovf = !e_b[XW-1] && (e_b >= XW'(MAX_E));

    // Gradual underflow: slide into the subnormal range, keeping every bit
    // that falls off the end as sticky.
    sh_amt  = e_le0 ? (XW'(1) - e_b) : '0;
    shifted = norm >> sh_amt;
    lost    = |(norm & ~({PW{1'b1}} << sh_amt));

    frac_p  = shifted[PW-2 -: FRAC_W];
    guard   = shifted[PW-SW-1];
    sticky  = lost | (|shifted[PW-SW-2:0]);
    inc     = guard & (sticky | frac_p[0]);

    // Leading bit still set means the value stayed normal. Adding the round
    // increment to {exp, frac} lets a mantissa carry bump the exponent, which
    // also lifts a subnormal to min-normal or a max-normal to infinity.
    exp_enc = shifted[PW-1] ? e_b[EXP_W-1:0] : '0;
    mag     = {exp_enc, frac_p};
    mag_r   = mag + (W-1)'(inc);

    if (special) begin
      rnd_res = spec_res;
    end else if (e_ovf) begin
      rnd_res = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
    end else begin
      rnd_res = {sign_r, mag_r};
    end
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge, independent of statement order.
  // NOTE: only control state and the outputs are reset. Operand and datapath
  // registers are always rewritten before anything reads them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_LOAD;
      cnt      <= '0;
      READY    <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ENABLE) begin
            if (cnt < CW'(NB)) a_reg <= W'({a_reg, DATA_IN});
            else               b_reg <= W'({b_reg, DATA_IN});
            if (cnt == CW'(2 * NB - 1)) begin
              cnt   <= '0;
              state <= S_CLASS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_CLASS: begin
          special  <= cls_special;
          spec_res <= cls_res;
          sign_r   <= res_sign;
          state    <= S_NORM;
        end

        S_NORM: begin
          a_shift <= PW'(a_sig_n);
          b_rem   <= KW'(b_sig_n);
          prod    <= '0;
          exp_sum <= a_exp_n + b_exp_n;
          cnt     <= '0;
          state   <= S_MULT;
        end

        S_MULT: begin
          prod    <= prod + a_shift * PW'(b_rem[MULT_STEP-1:0]);
          a_shift <= a_shift << MULT_STEP;
          b_rem   <= b_rem >> MULT_STEP;
          if (cnt == CW'(K - 1)) begin
            cnt   <= '0;
            state <= S_RND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RND: begin
          READY    <= 1'b1;
          DATA_OUT <= rnd_res[W-1 -: 8];
          out_sr   <= rnd_res << 8;
          cnt      <= '0;
          state    <= S_OUT;
        end

        S_OUT: begin
          if (cnt == CW'(NB - 1)) begin
            READY    <= 1'b0;
            DATA_OUT <= '0;
            cnt      <= '0;
            state    <= S_LOAD;
          end else begin
            DATA_OUT <= out_sr[W-1 -: 8];
            out_sr   <= out_sr << 8;
            cnt      <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_mult_serial.md
# fp_mult_serial

Parametrised byte-serial IEEE-754 multiplier, the successor to the fixed double-precision unit. It accepts two operands as a byte stream and computes their product with round-to-nearest-even. It covers full special-case and subnormal handling, including gradual underflow, and returns the result as a byte stream. It sits behind the same 8-bit host port as the existing FP blocks.

## Interface
- EXP_W, 11, exponent width (≥3)
- FRAC_W, 52, stored fraction width; 1+EXP_W+FRAC_W must be a multiple of 8 (NB = width/8 bytes)
- MULT_STEP, 14, multiplier-operand bits consumed per MULT cycle; K = ceil((FRAC_W+1)/MULT_STEP)
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, synchronous, active-high
- ENABLE  in  1  DATA_IN valid this cycle (honoured only in LOAD)
- DATA_IN  in  8  operand byte
- DATA_OUT  out  8  result byte, valid while READY; 0 otherwise
- READY  out  1  high exactly NB consecutive cycles per result

## Operation
- States: LOAD → CLASS → NORM → MULT (K cycles) → RND → OUT (NB cycles) → LOAD. Reset enters LOAD from any state: byte counter 0, READY 0, DATA_OUT 0, partial operands discarded.
- LOAD: each ENABLE cycle shifts one byte in, MSB first. The first NB bytes form A and the next NB form B. ENABLE-low gaps are allowed. The edge that captures byte 2·NB moves to CLASS.
- CLASS: classify A and B as zero, subnormal, normal, inf, or NaN. Result sign = signA^signB. Choose the special result with this priority:
  - A NaN → A with quiet bit (frac MSB) set.
  - B NaN → B quieted.
  - 0×inf → default NaN {0, all-ones, 1<<(FRAC_W-1)}.
  - inf×nonzero → signed inf.
  - zero operand → signed zero.
  - A special result bypasses arithmetic but still traverses NORM, MULT and RND (fixed latency).
- NORM: significand = {hidden, frac}, where hidden = 1 for normals. Subnormals are left-shifted to MSB=1 by a priority encoder, and their unbiased exponent becomes (1-bias-shift). Exponent math is signed, EXP_W+2 bits.
- MULT: iterative shift-add. Cycle i adds A_sig × B_sig[i·MULT_STEP +: MULT_STEP] << (i·MULT_STEP) into a 2(FRAC_W+1)-bit product.
- RND:
  - Normalise the product (shift 0/1, exp+1).
  - If biased exp ≤ 0, right-shift by 1-exp into subnormal range, OR-ing shifted-out bits into sticky.
  - Round RNE with guard/round/sticky. A mantissa carry increments the exponent, which also moves a subnormal to min-normal.
  - If biased exp ≥ all-ones, the result is signed inf.
- OUT: READY=1, DATA_OUT presents the result MSB byte first, one byte per cycle. ENABLE is ignored. The cycle after the last byte returns to LOAD with READY=0.

## Timing
- Define the capture edge of the last B byte as edge 0. READY rises after edge 3+K (edge 7 for default parameters) and falls after edge 3+K+NB.
- Latency does not depend on data or operand class.
- The next operand stream is accepted from the first LOAD cycle. ENABLE held high during OUT is dropped, not buffered.
- RESET asserted the same cycle as ENABLE takes priority; that byte is discarded.
- Byte counter wraps to 0 at each new LOAD; no residue is carried between operations.

## Test plan
- Default params, 0x3FF8000000000000 × 0x4000000000000000 → READY after edge 7, bytes 40 08 00 00 00 00 00 00.
- 0x3FF0000000000001 × 0x3FF0000000000001 → 0x3FF0000000000002 (sticky rounds down). 0x0000000000000001 × 0x3FE0000000000000 → 0x0000000000000000 (tie to even).
- Subnormal scaling: 0x0000000000000001 × 0x4330000000000000 → 0x0010000000000000. Overflow: 0x7FEFFFFFFFFFFFFF × 0x4000000000000000 → 0x7FF0000000000000.
- Specials: 0x8000000000000000 × 0x7FF0000000000000 → 0x7FF8000000000000. 0x7FF0000000000001 × 0x3FF0000000000000 → 0x7FF8000000000001. Both checks confirm latency is unchanged.
- EXP_W=5, FRAC_W=10, MULT_STEP=4: 0x3C00 × 0xC000 → READY after edge 6, bytes C0 00. ENABLE gaps during LOAD give the same result.
- RESET pulsed mid-MULT, then a fresh 1.5×2.0 stream → no READY from the aborted operation; the correct result follows with nominal latency.
